// File: rtl/quad_knob_tracker_pkg.sv
// Shared definitions for the Pmod rotary encoder position tracker: phase codes,
// header pin indices and the position limits of the three MemCont inputs.
package quad_knob_tracker_pkg;

   // Phase codes equal the filtered {B,A} pair, listed in Gray order
   typedef enum logic [1:0] {
      P00 = 2'b00,
      P01 = 2'b01,
      P11 = 2'b11,
      P10 = 2'b10
   } phase_t;

   localparam int PIN_A   = 0;
   localparam int PIN_B   = 1;
   localparam int PIN_BTN = 2;
   localparam int PIN_SWT = 3;

   localparam int X_MAX_POS      = 159;
   localparam int Y_MAX_POS      = 119;
   localparam int COLOUR_MAX_POS = 255;

   function automatic phase_t phase_fwd(input phase_t p);
      case (p)
         P00:     return P01;
         P01:     return P11;
         P11:     return P10;
         default: return P00;
      endcase
   endfunction

   function automatic phase_t phase_rev(input phase_t p);
      case (p)
         P00:     return P10;
         P10:     return P11;
         P11:     return P01;
         default: return P00;
      endcase
   endfunction

endpackage

// File: rtl/quad_knob_tracker_if.sv
// Encoder header pins in, tracked position and status pulses out.
interface quad_knob_tracker_if;
   logic [3:0] enc_pins;
   logic [7:0] pos;
   logic       step_pulse;
   logic       step_dir;
   logic       home_pulse;
   logic       seq_err;
   logic       swt_level;

   modport master (
      output enc_pins,
      input  pos, step_pulse, step_dir, home_pulse, seq_err, swt_level
   );

   modport slave (
      input  enc_pins,
      output pos, step_pulse, step_dir, home_pulse, seq_err, swt_level
   );
endinterface

// File: rtl/quad_knob_tracker_enc_debounce_filter.sv
// One header pin: two-flop synchroniser followed by a debounce counter that
// accepts a new level only after it has been stable for DEBOUNCE_CYCLES cycles.
module enc_debounce_filter #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic level,
   output logic valid
);
   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_reg;
   logic          sync2_reg;
   logic [CW-1:0] cnt_reg;
   logic          level_reg;
   logic          first_reg;

   // Synchroniser keeps sampling through reset so the first filtered value is real
   always_ff @(posedge clk) begin
      sync1_reg <= pin;
      sync2_reg <= sync1_reg;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg   <= '0;
         level_reg <= 1'b0;
         first_reg <= 1'b1;
      end else if (first_reg) begin
         level_reg <= sync2_reg;
         first_reg <= 1'b0;
         cnt_reg   <= '0;
      end else if (sync2_reg != level_reg) begin
         if (cnt_reg == CNT_LAST) begin
            level_reg <= sync2_reg;
            cnt_reg   <= '0;
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end else begin
         cnt_reg <= '0;
      end
   end

   assign level = level_reg;
   assign valid = ~first_reg;
endmodule

// File: rtl/quad_knob_tracker.sv
// Rotary encoder tracker: debounced quadrature decoding into a bounded 8-bit
// position with detent counting, button-home and switch-selected fast step.
module quad_knob_tracker
   import quad_knob_tracker_pkg::*;
#(
   parameter int MAX_POS         = X_MAX_POS,
   parameter int HOME_POS        = 0,
   parameter int WRAP            = 0,
   parameter int EDGES_PER_STEP  = 4,
   parameter int FAST_STEP       = 8,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input logic               clk,
   input logic               rst,
   quad_knob_tracker_if.slave enc_bus
);
   localparam logic signed [3:0] SUB_UP = 4'(EDGES_PER_STEP);
   localparam logic signed [3:0] SUB_DN = -SUB_UP;
   localparam logic [8:0]        MAX9   = 9'(MAX_POS);
   localparam logic [8:0]        MOD9   = 9'(MAX_POS + 1);
   localparam logic [8:0]        FAST9  = 9'(FAST_STEP);
   localparam logic [7:0]        HOME8  = 8'(HOME_POS);

   logic [3:0] filt;
   logic [3:0] filt_valid;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_pin
         enc_debounce_filter #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_filt (
            .clk   (clk),
            .rst   (rst),
            .pin   (enc_bus.enc_pins[gi]),
            .level (filt[gi]),
            .valid (filt_valid[gi])
         );
      end
   endgenerate

   phase_t code;
   logic   btn;
   logic   swt;
   logic   all_valid;

   assign code      = phase_t'({filt[PIN_B], filt[PIN_A]});
   assign btn       = filt[PIN_BTN];
   assign swt       = filt[PIN_SWT];
   assign all_valid = &filt_valid;

   phase_t            phase_reg, phase_next;
   logic signed [3:0] sub_reg, sub_next;
   logic              primed_reg, primed_next;
   logic              btn_prev_reg, btn_prev_next;
   logic              step_up_reg, step_up_next;
   logic              step_dn_reg, step_dn_next;
   logic              home_req_reg, home_req_next;
   logic              seq_err_reg, seq_err_next;
   logic              btn_rise;

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_reg    <= P00;
         sub_reg      <= '0;
         primed_reg   <= 1'b0;
         btn_prev_reg <= 1'b0;
         step_up_reg  <= 1'b0;
         step_dn_reg  <= 1'b0;
         home_req_reg <= 1'b0;
         seq_err_reg  <= 1'b0;
      end else begin
         phase_reg    <= phase_next;
         sub_reg      <= sub_next;
         primed_reg   <= primed_next;
         btn_prev_reg <= btn_prev_next;
         step_up_reg  <= step_up_next;
         step_dn_reg  <= step_dn_next;
         home_req_reg <= home_req_next;
         seq_err_reg  <= seq_err_next;
      end
   end

   always_comb begin
      phase_next    = phase_reg;
      sub_next      = sub_reg;
      primed_next   = primed_reg;
      btn_prev_next = btn_prev_reg;
      step_up_next  = 1'b0;
      step_dn_next  = 1'b0;
      home_req_next = 1'b0;
      seq_err_next  = 1'b0;
      btn_rise      = 1'b0;
      if (!primed_reg) begin
         // First valid sample only establishes the phase and button history
         if (all_valid) begin
            phase_next    = code;
            primed_next   = 1'b1;
            btn_prev_next = btn;
         end
      end else begin
         btn_prev_next = btn;
         btn_rise      = btn & ~btn_prev_reg;
         if (code != phase_reg) begin
            phase_next = code;
            if (code == phase_fwd(phase_reg)) begin
               sub_next = sub_reg + 4'sd1;
            end else if (code == phase_rev(phase_reg)) begin
               sub_next = sub_reg - 4'sd1;
            end else begin
               sub_next     = '0;
               seq_err_next = 1'b1;
            end
         end
         if (sub_next == SUB_UP) begin
            step_up_next = 1'b1;
            sub_next     = '0;
         end else if (sub_next == SUB_DN) begin
            step_dn_next = 1'b1;
            sub_next     = '0;
         end
         // Home beats a coincident step; sub is already cleared by the step
         if (btn_rise) begin
            home_req_next = 1'b1;
            step_up_next  = 1'b0;
            step_dn_next  = 1'b0;
         end
      end
   end

   logic [7:0] pos_reg, pos_next;
   logic       dir_reg, dir_next;
   logic       step_pulse_reg, step_pulse_next;
   logic       home_pulse_reg, home_pulse_next;
   logic [8:0] pos9;
   logic [8:0] d9;
   logic [8:0] cand;

   always_ff @(posedge clk) begin
      if (rst) begin
         pos_reg        <= HOME8;
         dir_reg        <= 1'b0;
         step_pulse_reg <= 1'b0;
         home_pulse_reg <= 1'b0;
      end else begin
         pos_reg        <= pos_next;
         dir_reg        <= dir_next;
         step_pulse_reg <= step_pulse_next;
         home_pulse_reg <= home_pulse_next;
      end
   end

   always_comb begin
      pos9            = {1'b0, pos_reg};
      d9              = swt ? FAST9 : 9'd1;
      cand            = pos9;
      pos_next        = pos_reg;
      dir_next        = dir_reg;
      step_pulse_next = 1'b0;
      home_pulse_next = 1'b0;
      if (home_req_reg) begin
         pos_next        = HOME8;
         home_pulse_next = 1'b1;
      end else if (step_up_reg || step_dn_reg) begin
         if (step_up_reg) begin
            cand = pos9 + d9;
            if (cand > MAX9) begin
               cand = (WRAP != 0) ? (cand - MOD9) : MAX9;
            end
         end else if (pos9 < d9) begin
            cand = (WRAP != 0) ? (pos9 + MOD9 - d9) : 9'd0;
         end else begin
            cand = pos9 - d9;
         end
         dir_next        = step_up_reg;
         pos_next        = cand[7:0];
         step_pulse_next = (cand[7:0] != pos_reg);
      end
   end

   assign enc_bus.pos        = pos_reg;
   assign enc_bus.step_pulse = step_pulse_reg;
   assign enc_bus.step_dir   = dir_reg;
   assign enc_bus.home_pulse = home_pulse_reg;
   assign enc_bus.seq_err    = seq_err_reg;
   assign enc_bus.swt_level  = swt;
endmodule

// File: tb/tb_quad_knob_tracker.sv
// Bench for quad_knob_tracker: a saturating and a wrapping instance share one
// set of header pins and are compared against an event-level position model.
module tb_quad_knob_tracker;
   import quad_knob_tracker_pkg::*;

   localparam int MAXP = X_MAX_POS;
   localparam int HOME = 0;
   localparam int E    = 4;
   localparam int FAST = 8;
   localparam int DEB  = 4;
   localparam int H    = 10;

   typedef struct {
      logic [3:0] pins;
      int         exp_pos0;
      int         exp_pos1;
      int         exp_dir;
   } vec_t;

   logic       clk  = 1'b0;
   logic       rst  = 1'b1;
   logic [3:0] pins = 4'b0000;

   always #5 clk = ~clk;

   quad_knob_tracker_if k0 ();
   quad_knob_tracker_if k1 ();
   assign k0.enc_pins = pins;
   assign k1.enc_pins = pins;

   quad_knob_tracker #(
      .MAX_POS(MAXP), .HOME_POS(HOME), .WRAP(0), .EDGES_PER_STEP(E),
      .FAST_STEP(FAST), .DEBOUNCE_CYCLES(DEB)
   ) dut0 (.clk(clk), .rst(rst), .enc_bus(k0));

   quad_knob_tracker #(
      .MAX_POS(MAXP), .HOME_POS(HOME), .WRAP(1), .EDGES_PER_STEP(E),
      .FAST_STEP(FAST), .DEBOUNCE_CYCLES(DEB)
   ) dut1 (.clk(clk), .rst(rst), .enc_bus(k1));

   int checks   = 0;
   int failures = 0;
   int txn      = 0;
   int seen_steps [2];
   int seen_homes [2];
   int seen_errs  [2];

   // Pulses are counted at the edge that ends their cycle
   always @(posedge clk) begin
      if (k0.step_pulse) seen_steps[0]++;
      if (k1.step_pulse) seen_steps[1]++;
      if (k0.home_pulse) seen_homes[0]++;
      if (k1.home_pulse) seen_homes[1]++;
      if (k0.seq_err)    seen_errs[0]++;
      if (k1.seq_err)    seen_errs[1]++;
   end

   int         m_pos [2];
   int         m_sub;
   int         m_dir;
   logic [3:0] m_pins;
   int         m_steps [2];
   int         m_homes;
   int         m_errs;
   vec_t       tbl [21];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int gray_idx(input logic [1:0] c);
      case (c)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   function automatic logic [1:0] gray_code(input int i);
      case (i)
         0:       return 2'b00;
         1:       return 2'b01;
         2:       return 2'b11;
         default: return 2'b10;
      endcase
   endfunction

   function automatic int next_pos(input int p, input bit up, input int d, input bit wrap);
      int v;
      v = up ? p + d : p - d;
      if (v > MAXP) v = wrap ? v - (MAXP + 1) : MAXP;
      if (v < 0)    v = wrap ? v + MAXP + 1 : 0;
      return v;
   endfunction

   task automatic model_reset();
      m_pos[0] = HOME;
      m_pos[1] = HOME;
      m_sub    = 0;
      m_dir    = 0;
      m_pins   = pins;
   endtask

   // One settled change of the header pins, judged by Gray-index distance
   task automatic model_update(input logic [3:0] np);
      int diff;
      int d;
      int v;
      bit step;
      bit up;
      diff = (gray_idx(np[1:0]) - gray_idx(m_pins[1:0]) + 4) % 4;
      d    = np[3] ? FAST : 1;
      step = 1'b0;
      up   = 1'b0;
      if (diff == 1) begin
         m_sub++;
         if (m_sub == E) begin step = 1'b1; up = 1'b1; m_sub = 0; end
      end else if (diff == 3) begin
         m_sub--;
         if (m_sub == -E) begin step = 1'b1; up = 1'b0; m_sub = 0; end
      end else if (diff == 2) begin
         m_sub = 0;
         m_errs++;
      end
      if (np[2] && !m_pins[2]) begin
         m_pos[0] = HOME;
         m_pos[1] = HOME;
         m_homes++;
      end else if (step) begin
         m_dir = up ? 1 : 0;
         for (int i = 0; i < 2; i++) begin
            v = next_pos(m_pos[i], up, d, i == 1);
            if (v != m_pos[i]) m_steps[i]++;
            m_pos[i] = v;
         end
      end
      m_pins = np;
   endtask

   task automatic compare_model(input string tag);
      check({tag, "_pos0"},  int'(k0.pos),       m_pos[0]);
      check({tag, "_pos1"},  int'(k1.pos),       m_pos[1]);
      check({tag, "_dir0"},  int'(k0.step_dir),  m_dir);
      check({tag, "_dir1"},  int'(k1.step_dir),  m_dir);
      check({tag, "_steps0"}, seen_steps[0],     m_steps[0]);
      check({tag, "_steps1"}, seen_steps[1],     m_steps[1]);
      check({tag, "_homes0"}, seen_homes[0],     m_homes);
      check({tag, "_homes1"}, seen_homes[1],     m_homes);
      check({tag, "_errs0"},  seen_errs[0],      m_errs);
      check({tag, "_errs1"},  seen_errs[1],      m_errs);
      check({tag, "_swt"},   int'(k0.swt_level), int'(m_pins[3]));
   endtask

   task automatic log_txn(input logic [3:0] np);
      txn++;
      $display("txn %0d pins=%b pos0=%0d pos1=%0d dir=%0d", txn, np, k0.pos, k1.pos, k0.step_dir);
   endtask

   task automatic apply(input logic [3:0] np);
      pins = np;
      repeat (H) @(negedge clk);
      model_update(np);
      log_txn(np);
      compare_model($sformatf("txn%0d", txn));
   endtask

   task automatic step_edge(input int dir);
      apply({pins[3:2], gray_code((gray_idx(pins[1:0]) + dir + 4) % 4)});
   endtask

   task automatic turn(input int dir);
      repeat (4) step_edge(dir);
   endtask

   task automatic home_press();
      apply(pins | 4'b0100);
      apply(pins & 4'b1011);
   endtask

   task automatic set_swt(input logic s);
      apply({s, pins[2:0]});
   endtask

   // Short pulse on one pin that the filter must swallow
   task automatic glitch(input int b);
      logic [3:0] save;
      int         swt_bad;
      save    = pins;
      swt_bad = 0;
      pins[b] = ~pins[b];
      repeat (DEB - 1) begin
         @(negedge clk);
         if (k0.swt_level != save[3]) swt_bad++;
      end
      pins = save;
      repeat (H) begin
         @(negedge clk);
         if (k0.swt_level != save[3]) swt_bad++;
      end
      log_txn(save);
      check($sformatf("glitch%0d_swt_level", b), swt_bad, 0);
      compare_model($sformatf("glitch%0d", b));
   endtask

   initial begin
      int s0;
      int s1;
      int h0;

      tbl[0]  = '{4'b0001, 1, 1, 1};
      tbl[1]  = '{4'b0011, 1, 1, 1};
      tbl[2]  = '{4'b0010, 1, 1, 1};
      tbl[3]  = '{4'b0000, 2, 2, 1};
      tbl[4]  = '{4'b0010, 2, 2, 1};
      tbl[5]  = '{4'b0011, 2, 2, 1};
      tbl[6]  = '{4'b0001, 2, 2, 1};
      tbl[7]  = '{4'b0000, 1, 1, 0};
      tbl[8]  = '{4'b0001, 1, 1, 0};
      tbl[9]  = '{4'b0000, 1, 1, 0};
      tbl[10] = '{4'b0011, 1, 1, 0};
      tbl[11] = '{4'b0010, 1, 1, 0};
      tbl[12] = '{4'b0000, 1, 1, 0};
      tbl[13] = '{4'b0001, 1, 1, 0};
      tbl[14] = '{4'b0011, 2, 2, 1};
      tbl[15] = '{4'b1011, 2, 2, 1};
      tbl[16] = '{4'b1001, 2, 2, 1};
      tbl[17] = '{4'b1000, 2, 2, 1};
      tbl[18] = '{4'b1010, 2, 2, 1};
      tbl[19] = '{4'b1011, 0, 154, 0};
      tbl[20] = '{4'b0011, 0, 154, 0};

      m_steps[0] = 0; m_steps[1] = 0; m_homes = 0; m_errs = 0;

      // Reset values
      pins = 4'b0000;
      rst  = 1'b1;
      repeat (4) @(negedge clk);
      check("rst_pos0",       int'(k0.pos),        HOME);
      check("rst_pos1",       int'(k1.pos),        HOME);
      check("rst_step_pulse", int'(k0.step_pulse), 0);
      check("rst_home_pulse", int'(k0.home_pulse), 0);
      check("rst_seq_err",    int'(k0.seq_err),    0);
      check("rst_step_dir",   int'(k0.step_dir),   0);
      check("rst_swt_level",  int'(k0.swt_level),  0);
      rst = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);

      // One forward detent, with the exact latency of its last edge
      apply(4'b0001);
      apply(4'b0011);
      apply(4'b0010);
      s0   = seen_steps[0];
      pins = 4'b0000;
      repeat (7) @(negedge clk);
      check("t1_pos_edge7",   int'(k0.pos), 0);
      check("t1_steps_edge7", seen_steps[0] - s0, 0);
      @(negedge clk);
      check("t1_pos_edge8",   int'(k0.pos), 1);
      check("t1_pulse_edge8", int'(k0.step_pulse), 1);
      check("t1_dir_edge8",   int'(k0.step_dir), 1);
      @(negedge clk);
      check("t1_pulse_edge9", int'(k0.step_pulse), 0);
      repeat (H - 9) @(negedge clk);
      model_update(4'b0000);
      log_txn(4'b0000);
      compare_model("t1");

      for (int i = 0; i < 21; i++) begin
         apply(tbl[i].pins);
         check($sformatf("vec%0d_pos0", i), int'(k0.pos),      tbl[i].exp_pos0);
         check($sformatf("vec%0d_pos1", i), int'(k1.pos),      tbl[i].exp_pos1);
         check($sformatf("vec%0d_dir", i),  int'(k0.step_dir), tbl[i].exp_dir);
      end

      glitch(PIN_A);
      glitch(PIN_SWT);
      turn(1);
      check("glitch_then_turn_pos0", int'(k0.pos), 1);

      // Top boundary: saturate versus wrap
      home_press();
      set_swt(1'b1);
      repeat (19) turn(1);
      set_swt(1'b0);
      repeat (7) turn(1);
      check("t2_top_pos0", int'(k0.pos), MAXP);
      check("t2_top_pos1", int'(k1.pos), MAXP);
      s0 = seen_steps[0];
      s1 = seen_steps[1];
      turn(1);
      check("t2_sat_pos0",   int'(k0.pos), MAXP);
      check("t2_sat_steps0", seen_steps[0] - s0, 0);
      check("t2_wrap_pos1",  int'(k1.pos), 0);
      check("t2_wrap_steps1", seen_steps[1] - s1, 1);

      // Bottom boundary with fast step
      home_press();
      set_swt(1'b1);
      turn(-1);
      check("t3_pos0", int'(k0.pos), 0);
      check("t3_pos1", int'(k1.pos), 152);
      set_swt(1'b0);

      // Button arriving with the completing edge of a detent
      home_press();
      set_swt(1'b1);
      repeat (4) turn(1);
      set_swt(1'b0);
      repeat (5) turn(1);
      check("t6_setup_pos0", int'(k0.pos), 37);
      check("t6_setup_pos1", int'(k1.pos), 37);
      repeat (3) step_edge(1);
      s0 = seen_steps[0];
      h0 = seen_homes[0];
      apply(4'b0111);
      check("t6_pos0",  int'(k0.pos), 0);
      check("t6_pos1",  int'(k1.pos), 0);
      check("t6_home",  seen_homes[0] - h0, 1);
      check("t6_steps", seen_steps[0] - s0, 0);
      apply(4'b0011);

      // Reset with a partial detent pending
      turn(1);
      step_edge(1);
      step_edge(1);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_pos0", int'(k0.pos), HOME);
      check("mid_rst_dir0", int'(k0.step_dir), 0);
      rst = 1'b0;
      model_reset();
      repeat (4) @(negedge clk);
      step_edge(1);
      step_edge(1);
      check("mid_rst_half_pos0", int'(k0.pos), 0);
      step_edge(1);
      step_edge(1);
      check("mid_rst_full_pos0", int'(k0.pos), 1);

      // Randomised rotation, jumps, switch, button and glitches
      for (int n = 0; n < 100; n++) begin
         int r;
         r = int'($urandom_range(0, 10));
         if (r <= 3)       step_edge(1);
         else if (r <= 6)  step_edge(-1);
         else if (r == 7)  apply({pins[3:2], ~pins[1:0]});
         else if (r == 8)  set_swt(~pins[3]);
         else if (r == 9)  home_press();
         else              glitch(int'($urandom_range(0, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
